// File: rtl/wishbone_bridge.sv
// Bridges the CPU's single-cycle memory port onto a Wishbone B4 classic master.
// Holds the core with `stall` while a cycle is outstanding; a timeout aborts silent cycles.
module wishbone_bridge #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       request,
  input  logic [ADDRESS_WIDTH-1:0]   address,
  input  logic                       write_enable,
  input  logic [DATA_WIDTH-1:0]      write_data,
  output logic [DATA_WIDTH-1:0]      read_data,
  output logic                       stall,
  output logic                       bus_error,
  output logic                       wb_cyc,
  output logic                       wb_stb,
  output logic                       wb_we,
  output logic [ADDRESS_WIDTH-1:0]   wb_adr,
  output logic [DATA_WIDTH-1:0]      wb_dat_o,
  output logic [DATA_WIDTH/8-1:0]    wb_sel,
  input  logic [DATA_WIDTH-1:0]      wb_dat_i,
  input  logic                       wb_ack,
  input  logic                       wb_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] count;
  logic             timed_out;
  logic             bus_exit;
  logic             fail_exit;

  assign timed_out = (count == LAST_COUNT);
  assign bus_exit  = wb_err || wb_ack || timed_out;
  // wb_err outranks wb_ack; a timeout only counts when the slave stayed silent.
  assign fail_exit = wb_err || (!wb_ack && timed_out);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (request) state_next = BUS;
      BUS:     if (bus_exit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = request;
      BUS:     stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_cyc    <= 1'b0;
      wb_stb    <= 1'b0;
      wb_we     <= 1'b0;
      wb_adr    <= '0;
      wb_dat_o  <= '0;
      wb_sel    <= '0;
      read_data <= '0;
      bus_error <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            wb_sel   <= '1;
            wb_we    <= write_enable;
            wb_adr   <= address;
            wb_dat_o <= write_data;
            count    <= '0;
          end
        end
        BUS: begin
          count <= count + 1'b1;
          if (bus_exit) begin
            wb_cyc <= 1'b0;
            wb_stb <= 1'b0;
            wb_sel <= '0;
            if (fail_exit) begin
              bus_error <= 1'b1;
              read_data <= '0;
            end else if (!wb_we) begin
              read_data <= wb_dat_i;
            end
          end
        end
        DONE: begin
          bus_error <= 1'b0;
        end
        default: begin
          bus_error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_bridge.sv
// Scoreboard bench for wishbone_bridge: stimulus queues expected bus/completion records,
// a negedge monitor pops and compares them as Wishbone cycles start and complete.
module tb_wishbone_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  localparam int MODE_ACK    = 0;
  localparam int MODE_ERRACK = 1;
  localparam int MODE_SILENT = 2;
  localparam int MODE_ERR    = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          request = 1'b0;
  logic [AW-1:0] address = '0;
  logic          write_enable = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic [DW-1:0] read_data;
  logic          stall;
  logic          bus_error;
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o;
  logic [DW/8-1:0] wb_sel;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_ack = 1'b0;
  logic          wb_err = 1'b0;

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
  } bus_exp_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            len;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];

  int checks = 0;
  int passes = 0;

  int            slave_mode = MODE_ACK;
  int            slave_waits = 0;
  logic [DW-1:0] slave_data = '0;
  int            slave_count = 0;

  wishbone_bridge #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .request(request),
    .address(address),
    .write_enable(write_enable),
    .write_data(write_data),
    .read_data(read_data),
    .stall(stall),
    .bus_error(bus_error),
    .wb_cyc(wb_cyc),
    .wb_stb(wb_stb),
    .wb_we(wb_we),
    .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o),
    .wb_sel(wb_sel),
    .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack),
    .wb_err(wb_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    else
      passes++;
  endtask

  task automatic noteFailure(input string name);
    checks++;
    $display("[TB] FAIL %s: got event, expected none at %0t", name, $time);
  endtask

  // Slave responds after a programmable number of wait states, driven mid-cycle.
  always @(negedge clock) begin
    if (!reset || !wb_cyc) begin
      wb_ack = 1'b0;
      wb_err = 1'b0;
      slave_count = 0;
    end else begin
      if (slave_mode != MODE_SILENT && slave_count == slave_waits) begin
        wb_ack   = (slave_mode == MODE_ACK) || (slave_mode == MODE_ERRACK);
        wb_err   = (slave_mode == MODE_ERRACK) || (slave_mode == MODE_ERR);
        wb_dat_i = slave_data;
      end else begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
      end
      slave_count++;
    end
  end

  logic     prev_cyc = 1'b0;
  int       cyc_len = 0;
  bus_exp_t cur_bus;

  always @(negedge clock) begin
    logic      done;
    done_exp_t de;
    if (!reset) begin
      prev_cyc = 1'b0;
      cyc_len  = 0;
    end else begin
      done = prev_cyc && !wb_cyc;
      checkOutput("stall", 64'(stall), done ? 64'd0 : (wb_cyc ? 64'd1 : 64'(request)));
      checkOutput("stb_eq_cyc", 64'(wb_stb), 64'(wb_cyc));
      if (wb_cyc) begin
        if (!prev_cyc) begin
          cyc_len = 0;
          if (bus_q.size() == 0) noteFailure("unexpected_cycle");
          else cur_bus = bus_q.pop_front();
        end
        cyc_len++;
        checkOutput("wb_adr", 64'(wb_adr), 64'(cur_bus.adr));
        checkOutput("wb_we", 64'(wb_we), 64'(cur_bus.we));
        checkOutput("wb_sel", 64'(wb_sel), 64'hF);
        if (cur_bus.we) checkOutput("wb_dat_o", 64'(wb_dat_o), 64'(cur_bus.dat));
      end else if (done) begin
        if (done_q.size() == 0) begin
          noteFailure("unexpected_done");
        end else begin
          de = done_q.pop_front();
          checkOutput("read_data", 64'(read_data), 64'(de.rdata));
          checkOutput("bus_error", 64'(bus_error), 64'(de.err));
          checkOutput("cyc_length", 64'(cyc_len), 64'(de.len));
          checkOutput("sel_cleared", 64'(wb_sel), 64'd0);
        end
      end
      prev_cyc = wb_cyc;
    end
  end

  // Reset must take effect without a clock edge.
  always @(negedge reset) begin
    #1;
    checkOutput("rst_cyc", 64'(wb_cyc), 64'd0);
    checkOutput("rst_stb", 64'(wb_stb), 64'd0);
    checkOutput("rst_we", 64'(wb_we), 64'd0);
    checkOutput("rst_sel", 64'(wb_sel), 64'd0);
    checkOutput("rst_adr", 64'(wb_adr), 64'd0);
    checkOutput("rst_dat_o", 64'(wb_dat_o), 64'd0);
    checkOutput("rst_read_data", 64'(read_data), 64'd0);
    checkOutput("rst_bus_error", 64'(bus_error), 64'd0);
    checkOutput("rst_stall", 64'(stall), 64'(request));
  end

  task automatic waitDone();
    int guard;
    guard = 0;
    do begin
      @(posedge clock);
      #1;
      guard++;
    end while (stall && guard < 50);
    if (guard >= 50) noteFailure("done_wait_timeout");
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] wdat,
                               input int mode, input int waits, input logic [DW-1:0] sdat,
                               input logic [DW-1:0] exp_rdata, input logic exp_err, input int exp_len);
    slave_mode  = mode;
    slave_waits = waits;
    slave_data  = sdat;
    bus_q.push_back('{adr, we, wdat});
    done_q.push_back('{exp_rdata, exp_err, exp_len});
    request      = 1'b1;
    address      = adr;
    write_enable = we;
    write_data   = wdat;
    waitDone();
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;

    applyStimulus(32'h0000_0100, 1'b0, 32'h0, MODE_ACK, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1);
    request = 1'b0;
    @(posedge clock); #1;

    applyStimulus(32'h0000_2004, 1'b1, 32'h1234_5678, MODE_ACK, 3, 32'h0, 32'hDEAD_BEEF, 1'b0, 4);
    request = 1'b0;
    @(posedge clock); #1;

    applyStimulus(32'h0000_0300, 1'b0, 32'h0, MODE_ERRACK, 0, 32'hAAAA_5555, 32'h0, 1'b1, 1);
    applyStimulus(32'h0000_0400, 1'b0, 32'h0, MODE_SILENT, 0, 32'h0, 32'h0, 1'b1, TO);
    applyStimulus(32'h0000_0500, 1'b0, 32'h0, MODE_ACK, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 2);
    applyStimulus(32'h0000_0608, 1'b1, 32'h0000_0077, MODE_ACK, 0, 32'h0, 32'h0BAD_F00D, 1'b0, 1);
    applyStimulus(32'h0000_0600, 1'b1, 32'h0000_0055, MODE_ERR, 2, 32'h0, 32'h0, 1'b1, 3);
    request = 1'b0;
    @(posedge clock); #1;

    // Abort a read during its second bus cycle; no completion is expected for it.
    slave_mode = MODE_SILENT;
    bus_q.push_back('{32'h0000_0700, 1'b0, 32'h0});
    request      = 1'b1;
    address      = 32'h0000_0700;
    write_enable = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    request = 1'b0;
    reset   = 1'b1;
    @(posedge clock); #1;

    applyStimulus(32'h0000_0800, 1'b0, 32'h0, MODE_ACK, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1);
    applyStimulus(32'h0000_0010, 1'b0, 32'h0, MODE_ACK, 0, 32'h1111_1111, 32'h1111_1111, 1'b0, 1);
    applyStimulus(32'h0000_0014, 1'b0, 32'h0, MODE_ACK, 0, 32'h2222_2222, 32'h2222_2222, 1'b0, 1);
    request = 1'b0;

    repeat (4) @(posedge clock);
    #1;
    checkOutput("bus_queue_empty", 64'(bus_q.size()), 64'd0);
    checkOutput("done_queue_empty", 64'(done_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish by 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
